pc_sequencer: RTL and testbench

//   Control sequencer for the 9-bit program counter. Owns the PC's Init/Halt/Branch/JP

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decoder <-> PC-sequencer bundle: run handshake, control op, jump-table config and
// the control lines the sequencer drives into the program counter.
interface pc_sequencer_if #(
    parameter int PC_W  = 9,
    parameter int LUT_W = 4
);
    logic             Start;
    logic [2:0]       Op;
    logic [LUT_W-1:0] Target;
    logic             ZeroFlag;
    logic             Stall;
    logic [PC_W-1:0]  PC;
    logic             CfgWe;
    logic [LUT_W-1:0] CfgAddr;
    logic [PC_W-1:0]  CfgData;
    logic             PcInit;
    logic             Halt;
    logic             Branch;
    logic [PC_W-1:0]  JP;
    logic             Done;
    logic             Fault;

    modport master (
        output Start, Op, Target, ZeroFlag, Stall, PC, CfgWe, CfgAddr, CfgData,
        input  PcInit, Halt, Branch, JP, Done, Fault
    );

    modport slave (
        input  Start, Op, Target, ZeroFlag, Stall, PC, CfgWe, CfgAddr, CfgData,
        output PcInit, Halt, Branch, JP, Done, Fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter control sequencer: Start/Done run handshake, jump-table branch
// resolution and a fixed-depth call/return stack with overflow/underflow fault.
module pc_sequencer #(
    parameter int PC_W  = 9,
    parameter int LUT_W = 4,
    parameter int STK_D = 4
) (
    input  logic          CLK,
    input  logic          Init,
    pc_sequencer_if.slave bus
);
    localparam int SP_W  = $clog2(STK_D + 1);
    localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_BRZ  = 3'd1;
    localparam logic [2:0] OP_BRNZ = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SP_W-1:0]  r_sp;
    logic [SP_W-1:0]  w_sp_dec;
    logic [PC_W-1:0]  r_lut   [2**LUT_W];
    logic [PC_W-1:0]  r_stack [STK_D];
    logic [PC_W-1:0]  w_lut_rd;
    logic [PC_W-1:0]  w_top;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_halt;
    logic             w_branch;
    logic [PC_W-1:0]  w_jp;
    logic             w_done;
    logic             w_fault;

    // Table read sees the pre-edge contents, so a same-cycle write is not forwarded.
    assign w_lut_rd = r_lut[bus.Target];
    assign w_sp_dec = r_sp - SP_W'(1);
    assign w_top    = r_stack[w_sp_dec[IDX_W-1:0]];
    assign w_full   = (r_sp == SP_W'(STK_D));
    assign w_empty  = (r_sp == {SP_W{1'b0}});

    // Control decode: PC lines must be valid in the same cycle the PC acts on them.
    always_comb begin
        w_next   = r_state;
        w_halt   = 1'b0;
        w_branch = 1'b0;
        w_jp     = {PC_W{1'b0}};
        w_done   = 1'b0;
        w_fault  = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_halt = 1'b1;
                if (bus.Start) w_next = S_CLR;
                else           w_next = S_IDLE;
            end
            S_CLR: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                if (bus.Stall) begin
                    w_halt = 1'b1;
                end else begin
                    case (bus.Op)
                        OP_NONE: w_branch = 1'b0;
                        OP_BRZ: begin
                            w_branch = bus.ZeroFlag;
                            w_jp     = w_lut_rd;
                        end
                        OP_BRNZ: begin
                            w_branch = ~bus.ZeroFlag;
                            w_jp     = w_lut_rd;
                        end
                        OP_JMP: begin
                            w_branch = 1'b1;
                            w_jp     = w_lut_rd;
                        end
                        OP_CALL: begin
                            if (w_full) begin
                                w_halt = 1'b1;
                                w_next = S_FAULT;
                            end else begin
                                w_push   = 1'b1;
                                w_branch = 1'b1;
                                w_jp     = w_lut_rd;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_halt = 1'b1;
                                w_next = S_FAULT;
                            end else begin
                                w_pop    = 1'b1;
                                w_branch = 1'b1;
                                w_jp     = w_top;
                            end
                        end
                        OP_HALT: begin
                            w_halt = 1'b1;
                            w_next = S_DONE;
                        end
                        default: w_branch = 1'b0;
                    endcase
                end
            end
            S_DONE: begin
                w_halt = 1'b1;
                w_done = 1'b1;
                if (bus.Start) w_next = S_CLR;
                else           w_next = S_DONE;
            end
            S_FAULT: begin
                w_halt  = 1'b1;
                w_fault = 1'b1;
            end
            default: begin
                w_halt = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.PcInit = Init | (r_state == S_CLR);
    assign bus.Halt   = w_halt;
    assign bus.Branch = w_branch;
    assign bus.JP     = w_jp;
    assign bus.Done   = w_done;
    assign bus.Fault  = w_fault;

    // State, stack pointer and jump table; Init wins over any concurrent table write.
    always_ff @(posedge CLK) begin
        if (Init) begin
            r_state <= S_IDLE;
            r_sp    <= {SP_W{1'b0}};
            r_lut   <= '{default: {PC_W{1'b0}}};
        end else begin
            r_state <= w_next;
            if (bus.CfgWe) r_lut[bus.CfgAddr] <= bus.CfgData;
            if (r_state == S_CLR) begin
                r_sp <= {SP_W{1'b0}};
            end else if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= w_sp_dec;
            end else begin
                r_sp <= r_sp;
            end
        end
    end

    // Return-address storage; contents are don't-care until pushed.
    always_ff @(posedge CLK) begin
        if (w_push && !Init) r_stack[r_sp[IDX_W-1:0]] <= bus.PC + PC_W'(1);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural PC closes the loop and each cycle's
// control outputs and PC value are compared against hand-computed expectations.
module tb_pc_sequencer;
    localparam int PC_W  = 9;
    localparam int LUT_W = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] BRZ  = 3'd1;
    localparam logic [2:0] BRNZ = 3'd2;
    localparam logic [2:0] JMP  = 3'd3;
    localparam logic [2:0] CALL = 3'd4;
    localparam logic [2:0] RET  = 3'd5;
    localparam logic [2:0] HLT  = 3'd6;
    localparam logic [2:0] RSVD = 3'd7;

    typedef struct {
        logic            init, start;
        logic [2:0]      op;
        logic [3:0]      tgt;
        logic            zf, stall, we;
        logic [3:0]      wa;
        logic [8:0]      wd;
        logic            pcinit, halt, br;
        logic [8:0]      jp;
        logic            done, fault;
        logic [8:0]      pc;
    } vec_t;

    logic       clk = 1'b0;
    logic       init;
    logic [8:0] pc_m;
    int         total = 0;
    int         bad = 0;
    vec_t       tbl[$];

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .LUT_W(LUT_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .LUT_W(LUT_W), .STK_D(4)) dut (
        .CLK  (clk),
        .Init (init),
        .bus  (bus)
    );

    // Program counter as the sequencer expects it to behave.
    assign bus.PC = pc_m;
    always @(posedge clk) begin
        if (bus.PcInit)      pc_m <= 9'd0;
        else if (!bus.Halt)  pc_m <= bus.Branch ? bus.JP : pc_m + 9'd1;
    end

    function automatic vec_t mk(
        input logic i, input logic st, input logic [2:0] op, input logic [3:0] tg,
        input logic zf, input logic sl, input logic we, input logic [3:0] wa,
        input logic [8:0] wd, input logic pi, input logic hl, input logic br,
        input logic [8:0] jp, input logic dn, input logic ft, input logic [8:0] pc);
        vec_t v;
        v.init = i;   v.start = st; v.op = op;   v.tgt = tg;
        v.zf = zf;    v.stall = sl; v.we = we;   v.wa = wa;  v.wd = wd;
        v.pcinit = pi; v.halt = hl; v.br = br;   v.jp = jp;
        v.done = dn;  v.fault = ft; v.pc = pc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        logic [13:0] got, exp;
        @(negedge clk);
        init         = v.init;
        bus.Start    = v.start;
        bus.Op       = v.op;
        bus.Target   = v.tgt;
        bus.ZeroFlag = v.zf;
        bus.Stall    = v.stall;
        bus.CfgWe    = v.we;
        bus.CfgAddr  = v.wa;
        bus.CfgData  = v.wd;
        #1;
        got = {bus.PcInit, bus.Halt, bus.Branch, bus.JP, bus.Done, bus.Fault};
        exp = {v.pcinit, v.halt, v.br, v.jp, v.done, v.fault};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] outputs {pcinit,halt,branch,jp,done,fault}: got=%h expected=%h",
                     tag, idx, got, exp);
        end
        total++;
        if (pc_m !== v.pc) begin
            bad++;
            $display("FAIL %s[%0d] pc: got=%h expected=%h", tag, idx, pc_m, v.pc);
        end
    endtask

    initial begin
        init = H; bus.Start = L; bus.Op = NONE; bus.Target = 4'd0; bus.ZeroFlag = L;
        bus.Stall = L; bus.CfgWe = L; bus.CfgAddr = 4'd0; bus.CfgData = 9'd0;
        repeat (2) @(negedge clk);

        //            i  st op    tg    zf sl we wa    wd       pi hl br jp       dn fl pc
        tbl.push_back(mk(H, L, NONE, 4'd0, L, L, H, 4'd3, 9'h040, H, H, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, H, 4'd3, 9'h040, L, H, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, H, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, L, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, L, L, 9'h000, L, L, 9'h001));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, L, L, 9'h000, L, L, 9'h002));
        tbl.push_back(mk(L, L, BRZ,  4'd3, H, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h003));
        tbl.push_back(mk(L, L, BRZ,  4'd3, L, L, L, 4'd0, 9'h000, L, L, L, 9'h040, L, L, 9'h040));
        tbl.push_back(mk(L, L, BRNZ, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h041));
        tbl.push_back(mk(L, L, RSVD, 4'd3, H, L, H, 4'd5, 9'h010, L, L, L, 9'h000, L, L, 9'h040));
        tbl.push_back(mk(L, L, JMP,  4'd5, L, L, L, 4'd0, 9'h000, L, L, H, 9'h010, L, L, 9'h041));
        tbl.push_back(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h010));
        tbl.push_back(mk(L, L, RET,  4'd0, L, H, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h040));
        tbl.push_back(mk(L, L, RET,  4'd0, L, L, L, 4'd0, 9'h000, L, L, H, 9'h011, L, L, 9'h040));
        tbl.push_back(mk(L, L, RET,  4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h011));
        tbl.push_back(mk(L, H, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, H, 9'h011));
        tbl.push_back(mk(H, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, H, L, 9'h000, L, H, 9'h011));
        tbl.push_back(mk(L, H, NONE, 4'd0, L, L, H, 4'd3, 9'h040, L, H, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h000));
        tbl.push_back(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h040));
        tbl.push_back(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h040));
        tbl.push_back(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h040, L, L, 9'h040));
        tbl.push_back(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h040));
        tbl.push_back(mk(L, H, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, H, 9'h040));
        tbl.push_back(mk(H, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, H, L, 9'h000, L, H, 9'h040));
        tbl.push_back(mk(L, H, NONE, 4'd0, L, L, H, 4'd3, 9'h040, L, H, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, HLT,  4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, H, L, 9'h000));
        tbl.push_back(mk(L, H, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, H, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, L, L, 9'h000, L, L, 9'h000));
        tbl.push_back(mk(L, L, RET,  4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h001));
        tbl.push_back(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, H, 9'h001));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "tbl", i);

        // Return address wraps at the top of the PC range; restart empties the stack.
        apply(mk(H, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, H, L, 9'h000, L, H, 9'h001), "wrap", 0);
        apply(mk(L, H, NONE, 4'd0, L, L, H, 4'd2, 9'h1FF, L, H, L, 9'h000, L, L, 9'h000), "wrap", 1);
        apply(mk(L, L, NONE, 4'd0, L, L, H, 4'd3, 9'h0AA, H, L, L, 9'h000, L, L, 9'h000), "wrap", 2);
        apply(mk(L, L, JMP,  4'd2, L, L, L, 4'd0, 9'h000, L, L, H, 9'h1FF, L, L, 9'h000), "wrap", 3);
        apply(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h0AA, L, L, 9'h1FF), "wrap", 4);
        apply(mk(L, L, RET,  4'd0, L, L, L, 4'd0, 9'h000, L, L, H, 9'h000, L, L, 9'h0AA), "wrap", 5);
        apply(mk(L, L, CALL, 4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h0AA, L, L, 9'h000), "wrap", 6);
        apply(mk(L, L, HLT,  4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h0AA), "wrap", 7);
        apply(mk(L, H, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, H, L, 9'h0AA), "wrap", 8);
        apply(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h0AA), "wrap", 9);
        apply(mk(L, L, RET,  4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h000), "wrap", 10);
        apply(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, H, 9'h000), "wrap", 11);

        // Init mid-run discards a concurrent table write; same-cycle write reads old value.
        apply(mk(H, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, H, L, 9'h000, L, H, 9'h000), "init", 0);
        apply(mk(L, H, NONE, 4'd0, L, L, H, 4'd3, 9'h040, L, H, L, 9'h000, L, L, 9'h000), "init", 1);
        apply(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h000), "init", 2);
        apply(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, L, L, 9'h000, L, L, 9'h000), "init", 3);
        apply(mk(H, L, NONE, 4'd0, L, L, H, 4'd3, 9'h1FF, H, L, L, 9'h000, L, L, 9'h001), "init", 4);
        apply(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h000), "init", 5);
        apply(mk(L, H, NONE, 4'd0, L, L, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h000), "init", 6);
        apply(mk(L, L, NONE, 4'd0, L, L, L, 4'd0, 9'h000, H, L, L, 9'h000, L, L, 9'h000), "init", 7);
        apply(mk(L, L, JMP,  4'd3, L, L, H, 4'd3, 9'h0AA, L, L, H, 9'h000, L, L, 9'h000), "init", 8);
        apply(mk(L, L, JMP,  4'd3, L, L, L, 4'd0, 9'h000, L, L, H, 9'h0AA, L, L, 9'h000), "init", 9);
        apply(mk(L, L, JMP,  4'd3, L, H, L, 4'd0, 9'h000, L, H, L, 9'h000, L, L, 9'h0AA), "init", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
